// File: rtl/cpu_trace_pkg.sv
// rtl/cpu_trace_pkg.sv - shared constants, record layout and beat FSM states for the CPU trace buffer
package cpu_trace_pkg;

  localparam int REC_W     = 128;
  localparam int PC_LSB    = 0;
  localparam int INSTR_LSB = 32;
  localparam int ALU_LSB   = 64;
  localparam int MEM_LSB   = 96;

  localparam logic [1:0] BEAT_PC    = 2'd0;
  localparam logic [1:0] BEAT_INSTR = 2'd1;
  localparam logic [1:0] BEAT_ALU   = 2'd2;
  localparam logic [1:0] BEAT_MEM   = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } trace_state_e;

  function automatic logic [31:0] beat_of(input logic [REC_W-1:0] rec, input logic [1:0] sel);
    logic [31:0] beat;
    case (sel)
      BEAT_PC:    beat = rec[PC_LSB    +: 32];
      BEAT_INSTR: beat = rec[INSTR_LSB +: 32];
      BEAT_ALU:   beat = rec[ALU_LSB   +: 32];
      default:    beat = rec[MEM_LSB   +: 32];
    endcase
    return beat;
  endfunction

endpackage

// File: rtl/cpu_trace_fifo.sv
// rtl/cpu_trace_fifo.sv - synchronous record FIFO with push/pop/full/empty/count
module cpu_trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = REC_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - retirement trace capture, drained as four 32-bit beats per record
// Optional PC range filter enabled by defining TRACE_FILTER_EN.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      alu_i,
  input  logic [31:0]      mem_i,
  input  logic [31:0]      pc_lo,
  input  logic [31:0]      pc_hi,
  input  logic             clr_ovf,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_sel,
  output logic             out_last,
  output logic [LW-1:0]    level,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);

  trace_state_e     state_q, state_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  logic             cap_pass, push_req, beat_fire, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [REC_W-1:0] head_rec, new_rec;

`ifdef TRACE_FILTER_EN
  assign cap_pass = (pc_i >= pc_lo) && (pc_i <= pc_hi);
`else
  logic unused_filter_bounds;
  assign unused_filter_bounds = ^{pc_lo, pc_hi};
  assign cap_pass = 1'b1;
`endif

  assign new_rec   = {mem_i, alu_i, instr_i, pc_i};
  assign push_req  = cap_en & cap_pass;
  assign beat_fire = out_valid & out_ready;
  assign pop       = beat_fire & (out_sel_q == BEAT_MEM);
  assign drop      = push_req & fifo_full & ~pop;

  cpu_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push_req),
    .wdata (new_rec),
    .pop   (pop),
    .rdata (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Leaving STREAM needs the last record popped with nothing arriving behind it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (push_req) state_d = ST_STREAM;
      ST_STREAM: if (pop && level == LW'(1) && !push_req) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_STREAM);
  end

  always_comb begin
    out_sel_d  = beat_fire ? out_sel_q + 2'd1 : out_sel_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (clr_ovf) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_sel_q  <= BEAT_PC;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      out_sel_q  <= out_sel_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_sel  = out_sel_q;
  assign out_last = (out_sel_q == BEAT_MEM);
  assign out_data = beat_of(head_rec, out_sel_q);
  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;

endmodule
